// File: rtl/bit_64_alu.sv
// bit_64_alu: registered 64-bit ALU built from 64 ripple-carry 1-bit slices
// Ports:
//    clk      - clock, all state updates on rising edge
//    rst      - synchronous active-high reset (result=0, overflow=0, zero=1)
//    a, b     - 64-bit operands
//    ALUop    - 4-bit operation select (AND, OR, ADD, SUB, SLT, NAND, NOR)
//    result   - registered 64-bit result
//    overflow - registered signed overflow flag (ADD/SUB only)
//    zero     - registered flag, set when result is zero
module bit_64_alu_slice (
   input  logic       a_i,
   input  logic       b_i,
   input  logic       ainv_i,
   input  logic       binv_i,
   input  logic       c_i,
   input  logic       less_i,
   input  logic [1:0] sel_i,
   output logic       r_o,
   output logic       c_o,
   output logic       s_o
);
   logic ax, bx;
   assign ax  = a_i ^ ainv_i;
   assign bx  = b_i ^ binv_i;
   assign s_o = ax ^ bx ^ c_i;
   assign c_o = (ax & bx) | (c_i & (ax ^ bx));
   assign r_o = sel_i == 2'd0 ? ax & bx :
                sel_i == 2'd1 ? ax | bx :
                sel_i == 2'd2 ? s_o : less_i;
endmodule

module bit_64_alu (
   input  logic        clk,
   input  logic        rst,
   input  logic [63:0] a,
   input  logic [63:0] b,
   input  logic [3:0]  ALUop,
   output logic [63:0] result,
   output logic        overflow,
   output logic        zero
);
   logic [63:0] res_q, res_d, slice_r;
   logic        ovf_q, ovf_d, zero_q, zero_d;
   logic        valid, ainv, binv, cin, is_arith, set;
   logic [1:0]  sel;
   logic        c_in63, c_out63, sum63;
   // NAND and NOR come from De Morgan: inverted inputs into OR and AND
   assign valid    = ALUop inside {4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1101};
   assign ainv     = ALUop[3];
   assign binv     = ALUop[2];
   assign cin      = ALUop == 4'b0110 || ALUop == 4'b0111;
   assign is_arith = ALUop == 4'b0010 || ALUop == 4'b0110;
   assign sel      = ALUop == 4'b1100 ? 2'd1 : ALUop == 4'b1101 ? 2'd0 : ALUop[1:0];
   // true signed a<b even when a-b overflows
   assign set      = sum63 ^ c_in63 ^ c_out63;
   for (genvar i = 0; i < 64; i++) begin : g_s
      logic ci, co, s;
      if (i == 0) begin : g_first
         assign ci = cin;
      end else begin : g_rest
         assign ci = g_s[i-1].co;
      end
      bit_64_alu_slice u_slice (
         .a_i   (a[i]),
         .b_i   (b[i]),
         .ainv_i(ainv),
         .binv_i(binv),
         .c_i   (ci),
         .less_i(i == 0 ? set : 1'b0),
         .sel_i (sel),
         .r_o   (slice_r[i]),
         .c_o   (co),
         .s_o   (s)
      );
      if (i == 63) begin : g_msb
         assign c_in63  = ci;
         assign c_out63 = co;
         assign sum63   = s;
      end
   end
   always_comb begin
      res_d  = valid ? slice_r : 64'd0;
      ovf_d  = is_arith & (c_in63 ^ c_out63);
      zero_d = res_d == 64'd0;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         res_q  <= 64'd0;
         ovf_q  <= 1'b0;
         zero_q <= 1'b1;
      end else begin
         res_q  <= res_d;
         ovf_q  <= ovf_d;
         zero_q <= zero_d;
      end
   end
   assign result   = res_q;
   assign overflow = ovf_q;
   assign zero     = zero_q;
endmodule

// File: tb/tb_bit_64_alu.sv
// tb_bit_64_alu: directed self-checking bench for bit_64_alu
module tb_bit_64_alu;
   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] a, b, result;
   logic [3:0]  ALUop;
   logic        overflow, zero;
   int          n_chk = 0, n_err = 0;
   localparam logic [3:0] AND_ = 4'b0000, OR_ = 4'b0001, ADD = 4'b0010, SUB = 4'b0110,
                          SLT = 4'b0111, NAND = 4'b1100, NOR_ = 4'b1101, BAD = 4'b1111;
   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF, MIN = 64'h8000_0000_0000_0000,
                           MAX = 64'h7FFF_FFFF_FFFF_FFFF;
   bit_64_alu dut (
      .clk     (clk),
      .rst     (rst),
      .a       (a),
      .b       (b),
      .ALUop   (ALUop),
      .result  (result),
      .overflow(overflow),
      .zero    (zero)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic run(input logic [63:0] av, input logic [63:0] bv, input logic [3:0] op);
      a = av;
      b = bv;
      ALUop = op;
      @(posedge clk);
      #1;
   endtask
   task automatic all3(input string tag, input logic [63:0] r, input logic o, input logic z);
      chk({tag, ".result"}, result, r);
      chk({tag, ".overflow"}, {63'd0, overflow}, {63'd0, o});
      chk({tag, ".zero"}, {63'd0, zero}, {63'd0, z});
   endtask
   initial begin
      rst = 1'b1;
      run(64'd45, 64'd44, ADD);
      all3("reset", 64'd0, 1'b0, 1'b1);
      rst = 1'b0;
      #3;
      all3("pre_edge", 64'd0, 1'b0, 1'b1);
      @(posedge clk);
      #1;
      all3("latency_add", 64'd89, 1'b0, 1'b0);
      a = 64'd7;
      b = 64'd9;
      ALUop = SUB;
      #3;
      all3("hold", 64'd89, 1'b0, 1'b0);
      run(64'd45, 64'd44, OR_);  all3("or", 64'd45, 1'b0, 1'b0);
      run(64'd45, 64'd44, AND_); all3("and", 64'd44, 1'b0, 1'b0);
      run(64'd45, 64'd44, NAND); all3("nand", 64'hFFFF_FFFF_FFFF_FFD3, 1'b0, 1'b0);
      run(64'd45, 64'd44, NOR_); all3("nor", 64'hFFFF_FFFF_FFFF_FFD2, 1'b0, 1'b0);
      run(64'd45, 64'd44, ADD);  all3("add", 64'd89, 1'b0, 1'b0);
      run(64'd0, 64'd1, SUB);    all3("sub_neg", ONES, 1'b0, 1'b0);
      run(64'd0, 64'd0, SUB);    all3("sub_zero", 64'd0, 1'b0, 1'b1);
      run(64'd0, 64'd1, SLT);    all3("slt_lt", 64'd1, 1'b0, 1'b0);
      run(64'd1, 64'd0, SLT);    all3("slt_ge", 64'd0, 1'b0, 1'b1);
      run(MIN, 64'd1, SLT);      all3("slt_ovf", 64'd1, 1'b0, 1'b0);
      run(MAX, ONES, SLT);       all3("slt_ovf2", 64'd0, 1'b0, 1'b1);
      run(64'd1, ONES, SLT);     all3("slt_neg_b", 64'd0, 1'b0, 1'b1);
      run(MAX, 64'd1, ADD);      all3("add_ovf", MIN, 1'b1, 1'b0);
      run(MIN, 64'd1, SUB);      all3("sub_ovf", MAX, 1'b1, 1'b0);
      run(ONES, 64'd1, ADD);     all3("add_wrap", 64'd0, 1'b0, 1'b1);
      run(64'd45, 64'd44, BAD);  all3("undef", 64'd0, 1'b0, 1'b1);
      run(64'd5, 64'd3, 4'b0011); all3("undef3", 64'd0, 1'b0, 1'b1);
      run(MAX, 64'd1, ADD);
      rst = 1'b1;
      run(MAX, 64'd1, ADD);      all3("mid_reset", 64'd0, 1'b0, 1'b1);
      rst = 1'b0;
      run(64'd45, 64'd44, SUB);  all3("after_reset", 64'd1, 1'b0, 1'b0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
